ccip_dfh_chain_responder: RTL and testbench
===========================================

Name: ccip_dfh_chain_responder

Overview:
- Parametrised MMIO responder that builds and serves a multi-feature DFH linked list for an AFU. The list holds NUM_FEATURES entries; entry 0 is the AFU header and the rest are BBB headers.
- Sits behind the CCI-P MMIO request decode. Serves DFH, UUID and per-feature scratch reads and writes with fixed 2-cycle read latency.
- New behaviour: each feature can be enabled at run time. Disabled features are skipped in the chain, and next offsets and EOL are recomputed.

Parameters:
- NUM_FEATURES, 4, number of feature slots (1..8).
- STRIDE_DW, 'h400, dword distance between feature bases (power of 2, ≥8).
- ADDR_W, 16, MMIO dword address width.
- FEATURE_IDS, 0, packed NUM_FEATURES×12-bit feature ids; slot i at [12i+:12].
- FEATURE_VERS, 0, packed NUM_FEATURES×4-bit versions.
- FEATURE_UUIDS, 0, packed NUM_FEATURES×128-bit UUIDs.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- feature_en  in  NUM_FEATURES  slot enable; bit 0 is ignored and treated as 1
- mmio_rd_valid  in  1  read request
- mmio_rd_addr  in  ADDR_W  dword address
- mmio_rd_len64  in  1  1 = 64-bit read, 0 = 32-bit read
- mmio_rd_tid  in  9  transaction id
- mmio_wr_valid  in  1  write request
- mmio_wr_addr  in  ADDR_W  dword address
- mmio_wr_len64  in  1  write size
- mmio_wr_data  in  64  write data
- mmio_rsp_valid  out  1  read response
- mmio_rsp_tid  out  9  echoed tid
- mmio_rsp_data  out  64  read data

Behaviour:
- Reset (async assert, sync deassert):
  - mmio_rsp_valid=0, mmio_rsp_tid=0, mmio_rsp_data=0.
  - All scratch registers =0.
  - Pipeline valids cleared, so in-flight reads are dropped and get no response.
- Decode:
  - slot = addr / STRIDE_DW; off = addr % STRIDE_DW.
  - off 0/1 = DFH, 2/3 = UUID[63:0], 4/5 = UUID[127:64], 6/7 = SCRATCH.
  - Any other off, slot ≥ NUM_FEATURES, or a disabled slot → data 0.
- DFH for enabled slot i:
  - f_type = 1 (AFU) for i=0, 2 (BBB) otherwise.
  - rsvd = 0; version = FEATURE_VERS[i]; id = FEATURE_IDS[i].
  - Let j = lowest enabled slot > i. If j exists: eol=0, next = (j−i)×STRIDE_DW×4 bytes, in 24 bits. Otherwise: eol=1, next=0.
  - Field order, MSB→LSB: type[63:60], rsvd[59:41], eol[40], next[39:16], version[15:12], id[11:0].
- Read pipeline:
  - Stage 1 registers the request and samples feature_en.
  - Stage 2 registers the response.
  - Request at cycle T → mmio_rsp_valid=1 at T+2 for exactly one cycle, carrying the matching tid.
  - Fully pipelined: one request per cycle, no backpressure, responses in order.
  - 64-bit read: returns the qword at addr with bit 0 cleared (an odd addr is treated as aligned down).
  - 32-bit read: returns the addressed dword in [31:0], with [63:32]=0.
- Writes:
  - Only SCRATCH is writable; all other writes are ignored.
  - 64-bit write at off 6 or 7 writes the full 64 bits.
  - 32-bit write at off 6 writes [31:0]; at off 7 writes [63:32] from wr_data[31:0].
  - Writes to a disabled slot still update its scratch, but reads of that slot return 0 while it is disabled.
- Simultaneous read and write to the same scratch in cycle T: the read returns the old value. A read issued at T+1 returns the new value.
- feature_en changes take effect for reads whose stage 1 occurs after the change. No glitch affects a response already in stage 2.

Test Plan:
- Reset, NUM_FEATURES=4, STRIDE_DW='h400, all enabled; read 64-bit addr 0 tid 5 → rsp at T+2, tid 5, type 1, eol 0, next 0x1000. Read addr 'hC00 → type 2, eol 1, next 0.
- feature_en=4'b1011; read slot1 DFH → next 0x2000 (skips slot 2). Read any addr in slot 2 → 0.
- Back-to-back reads at addr 2,3,4,5 (32-bit), tids 1..4, on consecutive cycles → four consecutive responses in order, each the UUID dwords with upper 32 bits 0.
- 64-bit write 0xDEADBEEF_CAFEF00D to slot 3 off 6, then 32-bit write 0x1234 at off 7; 64-bit read → 0x00001234_CAFEF00D. Same-cycle read+write → old value returned.
- Write attempts to DFH and UUID offsets, and reads at off 8 and slot ≥ NUM_FEATURES → DFH/UUID unchanged, unmapped reads return 0.
- Assert reset_n low with two reads in flight → no mmio_rsp_valid. After release, scratch reads return 0.

Source files
------------

// File: rtl/ccip_dfh_chain_responder.sv
// ---------------------------------------------------------------------------
// ccip_dfh_chain_responder
//
// MMIO responder serving a run-time reconfigurable DFH linked list. Each of
// NUM_FEATURES slots occupies STRIDE_DW dwords. Slot 0 is the AFU header, the
// remaining slots are BBB headers. Disabled slots drop out of the chain: the
// previous enabled header points past them, and the last enabled header
// carries EOL.
//
// Per-slot dword offsets:
//   0/1 DFH, 2/3 UUID[63:0], 4/5 UUID[127:64], 6/7 SCRATCH (read/write).
//   Everything else, slots >= NUM_FEATURES and disabled slots read as 0.
//
// Handshake: requests are valid-only (no ready). A read accepted in cycle T
// produces exactly one mmio_rsp_valid pulse in cycle T+2 with the same tid;
// responses come back in request order, one per cycle at full rate.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   feature_en           slot enables (bit 0 forced on)
//   mmio_rd_*            read request: valid, dword addr, 64-bit flag, tid
//   mmio_wr_*            write request: valid, dword addr, 64-bit flag, data
//   mmio_rsp_*           read response: valid, tid, data
// ---------------------------------------------------------------------------
module ccip_dfh_chain_responder #(
  parameter int NUM_FEATURES = 4,
  parameter int STRIDE_DW    = 'h400,
  parameter int ADDR_W       = 16,
  parameter logic [NUM_FEATURES*12-1:0]  FEATURE_IDS   = '0,
  parameter logic [NUM_FEATURES*4-1:0]   FEATURE_VERS  = '0,
  parameter logic [NUM_FEATURES*128-1:0] FEATURE_UUIDS = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_FEATURES-1:0] feature_en,
  input  logic                    mmio_rd_valid,
  input  logic [ADDR_W-1:0]       mmio_rd_addr,
  input  logic                    mmio_rd_len64,
  input  logic [8:0]              mmio_rd_tid,
  input  logic                    mmio_wr_valid,
  input  logic [ADDR_W-1:0]       mmio_wr_addr,
  input  logic                    mmio_wr_len64,
  input  logic [63:0]             mmio_wr_data,
  output logic                    mmio_rsp_valid,
  output logic [8:0]              mmio_rsp_tid,
  output logic [63:0]             mmio_rsp_data
);

  localparam int OFF_W  = $clog2(STRIDE_DW);
  localparam int SLOT_W = ADDR_W - OFF_W;
  localparam logic [31:0] NF_U = NUM_FEATURES;

  // DFH word for slot i given the enable vector seen by this read.
  function automatic logic [63:0] dfh_word(input int i, input logic [NUM_FEATURES-1:0] en);
    logic        found;
    int          nxt;
    logic [23:0] next_b;
    logic [3:0]  ftype;
    found = 1'b0;
    nxt   = 0;
    for (int j = 0; j < NUM_FEATURES; j++) begin
      if (!found && j > i && en[j]) begin
        found = 1'b1;
        nxt   = j;
      end
    end
    next_b = found ? 24'((nxt - i) * STRIDE_DW * 4) : 24'd0;
    ftype  = (i == 0) ? 4'd1 : 4'd2;
    return {ftype, 19'd0, ~found, next_b, FEATURE_VERS[4*i +: 4], FEATURE_IDS[12*i +: 12]};
  endfunction

  logic [63:0] r_scratch [NUM_FEATURES];

  // Request decode
  logic [31:0]      w_rd_slot;
  logic [OFF_W-1:0] w_rd_off;
  logic [31:0]      w_wr_slot;
  logic [OFF_W-1:0] w_wr_off;
  logic [63:0]      w_rd_scratch;

  assign w_rd_slot = 32'(mmio_rd_addr[ADDR_W-1:OFF_W]);
  assign w_rd_off  = mmio_rd_addr[OFF_W-1:0];
  assign w_wr_slot = 32'(mmio_wr_addr[ADDR_W-1:OFF_W]);
  assign w_wr_off  = mmio_wr_addr[OFF_W-1:0];

  // Scratch is captured in stage 1 so a same-cycle write is not yet visible.
  always_comb begin
    w_rd_scratch = '0;
    for (int k = 0; k < NUM_FEATURES; k++) begin
      if (w_rd_slot == 32'(k)) w_rd_scratch = r_scratch[k];
    end
  end

  // Stage 1: registered request, enables and scratch snapshot
  logic                    r_s1_valid;
  logic [31:0]             r_s1_slot;
  logic [OFF_W-1:0]        r_s1_off;
  logic                    r_s1_len64;
  logic [8:0]              r_s1_tid;
  logic [NUM_FEATURES-1:0] r_s1_en;
  logic [63:0]             r_s1_scratch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_slot    <= '0;
      r_s1_off     <= '0;
      r_s1_len64   <= 1'b0;
      r_s1_tid     <= '0;
      r_s1_en      <= '0;
      r_s1_scratch <= '0;
    end else begin
      r_s1_valid <= mmio_rd_valid;
      if (mmio_rd_valid) begin
        r_s1_slot    <= w_rd_slot;
        r_s1_off     <= w_rd_off;
        r_s1_len64   <= mmio_rd_len64;
        r_s1_tid     <= mmio_rd_tid;
        r_s1_en      <= feature_en | NUM_FEATURES'(1);
        r_s1_scratch <= w_rd_scratch;
      end
    end
  end

  // Stage 2 data selection
  logic [63:0]  w_dfh;
  logic [127:0] w_uuid;
  logic         w_slot_on;
  logic [63:0]  w_qword;
  logic [63:0]  w_rsp_data;

  always_comb begin
    w_dfh     = '0;
    w_uuid    = '0;
    w_slot_on = 1'b0;
    w_qword   = '0;
    for (int k = 0; k < NUM_FEATURES; k++) begin
      if (r_s1_slot == 32'(k)) begin
        w_dfh     = dfh_word(k, r_s1_en);
        w_uuid    = FEATURE_UUIDS[128*k +: 128];
        w_slot_on = r_s1_en[k];
      end
    end
    if (w_slot_on && r_s1_slot < NF_U) begin
      case (r_s1_off[OFF_W-1:1])
        (OFF_W-1)'(0): w_qword = w_dfh;
        (OFF_W-1)'(1): w_qword = w_uuid[63:0];
        (OFF_W-1)'(2): w_qword = w_uuid[127:64];
        (OFF_W-1)'(3): w_qword = r_s1_scratch;
        default:       w_qword = '0;
      endcase
    end
    if (r_s1_len64) w_rsp_data = w_qword;
    else            w_rsp_data = {32'd0, r_s1_off[0] ? w_qword[63:32] : w_qword[31:0]};
  end

  // Stage 2: registered response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mmio_rsp_valid <= 1'b0;
      mmio_rsp_tid   <= '0;
      mmio_rsp_data  <= '0;
    end else begin
      mmio_rsp_valid <= r_s1_valid;
      if (r_s1_valid) begin
        mmio_rsp_tid  <= r_s1_tid;
        mmio_rsp_data <= w_rsp_data;
      end
    end
  end

  // Scratch writes land regardless of the slot's enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_FEATURES; k++) r_scratch[k] <= '0;
    end else if (mmio_wr_valid) begin
      for (int k = 0; k < NUM_FEATURES; k++) begin
        if (w_wr_slot == 32'(k)) begin
          if (mmio_wr_len64 && (w_wr_off == OFF_W'(6) || w_wr_off == OFF_W'(7)))
            r_scratch[k] <= mmio_wr_data;
          else if (!mmio_wr_len64 && w_wr_off == OFF_W'(6))
            r_scratch[k][31:0] <= mmio_wr_data[31:0];
          else if (!mmio_wr_len64 && w_wr_off == OFF_W'(7))
            r_scratch[k][63:32] <= mmio_wr_data[31:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_ccip_dfh_chain_responder.sv
// ---------------------------------------------------------------------------
// Directed bench for ccip_dfh_chain_responder (4 slots, stride 'h400).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ccip_dfh_chain_responder;

  localparam int NF = 4;
  localparam logic [NF*12-1:0]  IDS   = {12'h0C4, 12'h0B3, 12'h0A2, 12'h001};
  localparam logic [NF*4-1:0]   VERS  = {4'h4, 4'h3, 4'h2, 4'h1};
  localparam logic [NF*128-1:0] UUIDS = {
    128'hC3C3C3C3_00000003_A5A5A5A5_00000030,
    128'hB2B2B2B2_00000002_5A5A5A5A_00000020,
    128'hA1A1A1A1_00000001_0F0F0F0F_00000010,
    128'h11112222_33334444_55556666_77778888};

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [NF-1:0] feature_en;
  logic          mmio_rd_valid, mmio_rd_len64, mmio_wr_valid, mmio_wr_len64;
  logic [15:0]   mmio_rd_addr, mmio_wr_addr;
  logic [8:0]    mmio_rd_tid;
  logic [63:0]   mmio_wr_data;
  logic          mmio_rsp_valid;
  logic [8:0]    mmio_rsp_tid;
  logic [63:0]   mmio_rsp_data;

  ccip_dfh_chain_responder #(
    .NUM_FEATURES(NF), .STRIDE_DW('h400), .ADDR_W(16),
    .FEATURE_IDS(IDS), .FEATURE_VERS(VERS), .FEATURE_UUIDS(UUIDS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .feature_en(feature_en),
    .mmio_rd_valid(mmio_rd_valid), .mmio_rd_addr(mmio_rd_addr),
    .mmio_rd_len64(mmio_rd_len64), .mmio_rd_tid(mmio_rd_tid),
    .mmio_wr_valid(mmio_wr_valid), .mmio_wr_addr(mmio_wr_addr),
    .mmio_wr_len64(mmio_wr_len64), .mmio_wr_data(mmio_wr_data),
    .mmio_rsp_valid(mmio_rsp_valid), .mmio_rsp_tid(mmio_rsp_tid),
    .mmio_rsp_data(mmio_rsp_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [72:0] exp_q[$];

  function automatic logic [63:0] mk_dfh(input logic [3:0] ftype, input logic eol,
                                         input logic [23:0] nxt, input logic [3:0] ver,
                                         input logic [11:0] id);
    return {ftype, 19'd0, eol, nxt, ver, id};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic rd_check(input string tag, input logic [15:0] addr, input logic len64,
                          input logic [8:0] tid, input logic [63:0] exp);
    @(negedge clk);
    mmio_rd_valid = 1'b1; mmio_rd_addr = addr; mmio_rd_len64 = len64; mmio_rd_tid = tid;
    @(negedge clk);
    mmio_rd_valid = 1'b0;
    check({tag, " early"}, 64'(mmio_rsp_valid), 64'd0);
    @(negedge clk);
    check({tag, " valid"}, 64'(mmio_rsp_valid), 64'd1);
    check({tag, " tid"}, 64'(mmio_rsp_tid), 64'(tid));
    check({tag, " data"}, mmio_rsp_data, exp);
    @(negedge clk);
    check({tag, " one-shot"}, 64'(mmio_rsp_valid), 64'd0);
  endtask

  task automatic wr(input logic [15:0] addr, input logic len64, input logic [63:0] data);
    @(negedge clk);
    mmio_wr_valid = 1'b1; mmio_wr_addr = addr; mmio_wr_len64 = len64; mmio_wr_data = data;
    @(negedge clk);
    mmio_wr_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [72:0] e;
    check({tag, " valid"}, 64'(mmio_rsp_valid), 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, " queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, " tid"}, 64'(mmio_rsp_tid), 64'(e[72:64]));
      check({tag, " data"}, mmio_rsp_data, e[63:0]);
    end
  endtask

  logic [63:0] uuid_dw [4];

  initial begin
    uuid_dw[0] = 64'h77778888; uuid_dw[1] = 64'h55556666;
    uuid_dw[2] = 64'h33334444; uuid_dw[3] = 64'h11112222;
    feature_en = 4'b1111;
    mmio_rd_valid = 1'b0; mmio_rd_addr = '0; mmio_rd_len64 = 1'b0; mmio_rd_tid = '0;
    mmio_wr_valid = 1'b0; mmio_wr_addr = '0; mmio_wr_len64 = 1'b0; mmio_wr_data = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst valid", 64'(mmio_rsp_valid), 64'd0);
    check("rst tid", 64'(mmio_rsp_tid), 64'd0);
    check("rst data", mmio_rsp_data, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // chain with all slots enabled
    rd_check("dfh0", 16'h0000, 1'b1, 9'd5, mk_dfh(4'd1, 1'b0, 24'h001000, 4'h1, 12'h001));
    rd_check("dfh3", 16'h0C00, 1'b1, 9'd6, mk_dfh(4'd2, 1'b1, 24'h000000, 4'h4, 12'h0C4));
    rd_check("dfh0 odd", 16'h0001, 1'b1, 9'd9, mk_dfh(4'd1, 1'b0, 24'h001000, 4'h1, 12'h001));
    rd_check("dfh0 lo32", 16'h0000, 1'b0, 9'd10, 64'h10001001);
    rd_check("dfh0 hi32", 16'h0001, 1'b0, 9'd11, 64'h10000000);
    rd_check("uuid3 hi", 16'h0C04, 1'b1, 9'd12, 64'hC3C3C3C3_00000003);

    // slot 2 disabled
    feature_en = 4'b1011;
    rd_check("dfh1 skip", 16'h0400, 1'b1, 9'd20, mk_dfh(4'd2, 1'b0, 24'h002000, 4'h2, 12'h0A2));
    rd_check("dfh2 off", 16'h0800, 1'b1, 9'd21, 64'd0);
    rd_check("uuid2 off", 16'h0802, 1'b1, 9'd22, 64'd0);
    feature_en = 4'b1010;
    rd_check("en0 forced", 16'h0000, 1'b1, 9'd23, mk_dfh(4'd1, 1'b0, 24'h001000, 4'h1, 12'h001));
    feature_en = 4'b1001;
    rd_check("dfh0 to 3", 16'h0000, 1'b1, 9'd24, mk_dfh(4'd1, 1'b0, 24'h003000, 4'h1, 12'h001));
    feature_en = 4'b0001;
    rd_check("dfh0 alone", 16'h0000, 1'b1, 9'd25, mk_dfh(4'd1, 1'b1, 24'h000000, 4'h1, 12'h001));
    feature_en = 4'b1111;

    // back-to-back 32-bit UUID reads
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k >= 2) pop_check("b2b");
      mmio_rd_valid = 1'b1; mmio_rd_addr = 16'(2 + k); mmio_rd_len64 = 1'b0;
      mmio_rd_tid = 9'(1 + k);
      exp_q.push_back({9'(1 + k), uuid_dw[k]});
    end
    @(negedge clk);
    pop_check("b2b");
    mmio_rd_valid = 1'b0;
    @(negedge clk);
    pop_check("b2b");
    @(negedge clk);
    check("b2b idle", 64'(mmio_rsp_valid), 64'd0);

    // scratch
    wr(16'h0C06, 1'b1, 64'hDEADBEEF_CAFEF00D);
    wr(16'h0C07, 1'b0, 64'h00001234);
    rd_check("scr3", 16'h0C06, 1'b1, 9'd30, 64'h00001234_CAFEF00D);
    rd_check("scr3 odd", 16'h0C07, 1'b1, 9'd31, 64'h00001234_CAFEF00D);
    rd_check("scr3 hi32", 16'h0C07, 1'b0, 9'd32, 64'h00001234);

    // same-cycle read and write
    @(negedge clk);
    mmio_rd_valid = 1'b1; mmio_rd_addr = 16'h0C06; mmio_rd_len64 = 1'b1; mmio_rd_tid = 9'd40;
    mmio_wr_valid = 1'b1; mmio_wr_addr = 16'h0C06; mmio_wr_len64 = 1'b1;
    mmio_wr_data = 64'h01234567_89ABCDEF;
    @(negedge clk);
    mmio_wr_valid = 1'b0; mmio_rd_tid = 9'd41;
    @(negedge clk);
    mmio_rd_valid = 1'b0;
    check("rw old tid", 64'(mmio_rsp_tid), 64'd40);
    check("rw old", mmio_rsp_data, 64'h00001234_CAFEF00D);
    @(negedge clk);
    check("rw new tid", 64'(mmio_rsp_tid), 64'd41);
    check("rw new", mmio_rsp_data, 64'h01234567_89ABCDEF);

    // disabled slot keeps scratch writes
    feature_en = 4'b1011;
    wr(16'h0806, 1'b1, 64'h00000055_00000066);
    wr(16'h0806, 1'b0, 64'hFFFFFFFF_AAAABBBB);
    rd_check("scr2 off", 16'h0806, 1'b1, 9'd50, 64'd0);
    feature_en = 4'b1111;
    rd_check("scr2 on", 16'h0806, 1'b1, 9'd51, 64'h00000055_AAAABBBB);

    // read-only and unmapped
    wr(16'h0C00, 1'b1, 64'hFFFFFFFF_FFFFFFFF);
    wr(16'h0C02, 1'b1, 64'hFFFFFFFF_FFFFFFFF);
    wr(16'h0C05, 1'b0, 64'hFFFFFFFF);
    wr(16'h0C08, 1'b1, 64'hFFFFFFFF_FFFFFFFF);
    rd_check("dfh3 ro", 16'h0C00, 1'b1, 9'd60, mk_dfh(4'd2, 1'b1, 24'h000000, 4'h4, 12'h0C4));
    rd_check("uuid3 ro", 16'h0C02, 1'b1, 9'd61, 64'hA5A5A5A5_00000030);
    rd_check("uuid3 hi ro", 16'h0C05, 1'b0, 9'd62, 64'hC3C3C3C3);
    rd_check("off8", 16'h0C08, 1'b1, 9'd63, 64'd0);
    rd_check("slot4", 16'h1000, 1'b1, 9'd64, 64'd0);
    rd_check("slot63", 16'hFC06, 1'b1, 9'd65, 64'd0);

    // reset with reads in flight
    @(negedge clk);
    mmio_rd_valid = 1'b1; mmio_rd_addr = 16'h0000; mmio_rd_len64 = 1'b1; mmio_rd_tid = 9'd70;
    @(negedge clk);
    mmio_rd_addr = 16'h0C06; mmio_rd_tid = 9'd71;
    #2 reset_n = 1'b0;
    mmio_rd_valid = 1'b0;
    #1 check("inflight rst", 64'(mmio_rsp_valid), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("inflight held", 64'(mmio_rsp_valid), 64'd0);
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("inflight dropped", 64'(mmio_rsp_valid), 64'd0);
    end
    rd_check("scr3 rst", 16'h0C06, 1'b1, 9'd72, 64'd0);
    rd_check("scr2 rst", 16'h0806, 1'b1, 9'd73, 64'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
